ram_serdes: RTL and testbench
=============================

RAM_SERDES -- requirements
Module: ram_serdes

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 1, legal range 1..4: bus turnaround cycles between address and read data.
REQ-002 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: a core-side request is present.
REQ-005 SHALL have port req_ready, output, 1: the block accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 32: byte address.
REQ-008 SHALL have port req_wdata, input, 32: write data.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32: read data, valid with rsp_valid on reads.
REQ-011 SHALL have port rsp_err, output, 1: error flag, valid with rsp_valid.
REQ-012 SHALL have port link_out, output, 16: data driven onto the external 16-bit RAM link.
REQ-013 SHALL have port link_oe, output, 1: output enable for link_out (tri-state control at the top level).
REQ-014 SHALL have port link_in, input, 16: data sampled from the external link.
REQ-015 SHALL have port link_strobe, output, 1: marks a valid address or data beat.
REQ-016 SHALL have port link_we, output, 1: direction of the current transaction.

Function
REQ-017 SHALL use FSM states IDLE, ADDR_LO, ADDR_HI, TURN, RD_LO, RD_HI, WR_LO, WR_HI, RESP.
REQ-018 SHALL assert req_ready only in IDLE; acceptance = req_valid & req_ready, latching req_we, req_addr and req_wdata.
REQ-019 SHALL sequence writes as IDLE->ADDR_LO->ADDR_HI->WR_LO->WR_HI->RESP->IDLE, one cycle per state.
REQ-020 SHALL sequence reads as IDLE->ADDR_LO->ADDR_HI->TURN (TURN_CYCLES cycles, counted by a down-counter)->RD_LO->RD_HI->RESP->IDLE.
REQ-021 SHALL drive address bits [15:0] in ADDR_LO and [31:16] in ADDR_HI; write data [15:0] in WR_LO and [31:16] in WR_HI.
REQ-022 SHALL hold link_oe=1 in ADDR_*/WR_*, and link_oe=0 in IDLE/TURN/RD_*/RESP; link_out SHALL be 0 whenever link_oe=0.
REQ-023 SHALL assert link_strobe in ADDR_*, WR_* and RD_* only; link_we SHALL equal the latched req_we from ADDR_LO through RESP and be 0 in IDLE.
REQ-024 SHALL capture link_in into rsp_rdata[15:0] at the end of RD_LO and into [31:16] at the end of RD_HI.
REQ-025 SHALL pulse rsp_valid for exactly one cycle in RESP; there is no response backpressure.
REQ-026 Latency from the acceptance cycle to rsp_valid SHALL be 5 cycles for writes and 5+TURN_CYCLES cycles for reads.
REQ-027 SHALL hold rsp_rdata stable until the next read completes; rsp_rdata SHALL be unchanged by writes.
REQ-028 SHALL accept a new request in the cycle after RESP (back-to-back); req_valid asserted during RESP SHALL NOT be accepted.

Reset
REQ-029 On rst_n low SHALL force IDLE immediately, regardless of state, with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, link_out=0, link_oe=0, link_strobe=0, link_we=0 and the turnaround counter at 0.
REQ-030 A transaction interrupted by reset SHALL be dropped with no response; the first rising edge after rst_n deasserts SHALL accept a request normally.

Configuration
REQ-031 With RAM_SERDES_ALIGN_CHK_EN defined, a request with req_addr[1:0]!=0 SHALL skip all link states (IDLE->RESP) and produce rsp_valid with rsp_err=1 on the next cycle, with rsp_rdata unchanged.
REQ-032 Without RAM_SERDES_ALIGN_CHK_EN, the block SHALL force req_addr[1:0] to 0 on the link and hold rsp_err constant 0.

Structure
REQ-033 SHALL take the state enum type and beat-width constant (16) from shared package ram_serdes_pkg.
REQ-034 SHALL be a single module with no sub-module; the turnaround counter is inline.

Verification
REQ-035 Write addr 0x0000_1234, data 0xDEAD_BEEF -> link_out 0x1234, 0x0000, 0xBEEF, 0xDEAD on consecutive strobed cycles with link_oe=1, link_we=1; rsp_valid 5 cycles after acceptance.
REQ-036 Read addr 0x0000_0010, TURN_CYCLES=2, link_in 0x5678 then 0x1234 in RD_LO and RD_HI -> rsp_rdata=0x1234_5678, rsp_valid 7 cycles after acceptance, link_oe=0 from TURN onward.
REQ-037 req_valid held high for two writes -> second accepted the cycle after RESP; req_ready=0 for the whole first transaction.
REQ-038 rst_n low during ADDR_HI -> link_oe and link_strobe drop asynchronously; no rsp_valid; next request completes correctly.
REQ-039 Address 0x0000_0002 with RAM_SERDES_ALIGN_CHK_EN -> no link_strobe, rsp_valid with rsp_err=1 one cycle after acceptance; without the macro -> link address 0x0000, rsp_err=0.

Source files
------------

// File: rtl/ram_serdes_pkg.sv
// Shared types and constants for the ram_serdes 32-bit to 16-bit RAM link bridge.
package ram_serdes_pkg;

  localparam int unsigned BeatW = 16;

  typedef enum logic [3:0] {
    StIdle,
    StAddrLo,
    StAddrHi,
    StTurn,
    StRdLo,
    StRdHi,
    StWrLo,
    StWrHi,
    StResp
  } state_e;

  function automatic logic [BeatW-1:0] beat_sel(input logic [2*BeatW-1:0] word, input logic hi);
    return hi ? word[2*BeatW-1:BeatW] : word[BeatW-1:0];
  endfunction

endpackage

// File: rtl/ram_serdes.sv
// Serialises 32-bit core requests onto a 16-bit external RAM link with bus turnaround on reads.
// Optional RAM_SERDES_ALIGN_CHK_EN: misaligned requests bypass the link and respond with an error.
module ram_serdes
  import ram_serdes_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [BeatW-1:0] link_out,
  output logic             link_oe,
  input  logic [BeatW-1:0] link_in,
  output logic             link_strobe,
  output logic             link_we
);

  localparam logic [2:0] TurnInit = 3'(TURN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  turn_q, turn_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept;
  logic        misaligned;

`ifdef RAM_SERDES_ALIGN_CHK_EN
  localparam logic [31:0] AddrMask = 32'hFFFF_FFFF;
  logic err_q;

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign rsp_err    = (state_q == StResp) & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
`else
  // Without the check, low address bits are simply dropped on the link.
  localparam logic [31:0] AddrMask = 32'hFFFF_FFFC;

  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign link_we   = (state_q != StIdle) & we_q;

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = misaligned ? StResp : StAddrLo;
      StAddrLo: state_d = StAddrHi;
      StAddrHi: begin
        if (we_q) begin
          state_d = StWrLo;
        end else begin
          state_d = StTurn;
          turn_d  = TurnInit;
        end
      end
      StTurn: begin
        if (turn_q == 3'd0) state_d = StRdLo;
        else                turn_d  = turn_q - 3'd1;
      end
      StRdLo:   state_d = StRdHi;
      StRdHi:   state_d = StResp;
      StWrLo:   state_d = StWrHi;
      StWrHi:   state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    link_out    = '0;
    link_oe     = 1'b0;
    link_strobe = 1'b0;
    unique case (state_q)
      StAddrLo, StAddrHi: begin
        link_oe     = 1'b1;
        link_strobe = 1'b1;
        link_out    = beat_sel(addr_q, state_q == StAddrHi);
      end
      StWrLo, StWrHi: begin
        link_oe     = 1'b1;
        link_strobe = 1'b1;
        link_out    = beat_sel(wdata_q, state_q == StWrHi);
      end
      StRdLo, StRdHi: link_strobe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      turn_q  <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr & AddrMask;
        wdata_q <= req_wdata;
      end
      if (state_q == StRdLo) rdata_q[BeatW-1:0]       <= link_in;
      if (state_q == StRdHi) rdata_q[2*BeatW-1:BeatW] <= link_in;
    end
  end

endmodule

// File: tb/tb_ram_serdes.sv
// Scoreboard bench for ram_serdes: models the external RAM link and checks beats and responses.
module tb_ram_serdes;

  localparam int TC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [15:0] data;
    logic        we;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] link_out;
  logic        link_oe, link_strobe, link_we;
  logic [15:0] link_in = 16'h0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  rsp_t        rsp_q[$];
  beat_t       beat_q[$];
  logic [15:0] rd_q[$];
  rsp_t        r;
  beat_t       b;

  ram_serdes #(.TURN_CYCLES(TC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .link_out   (link_out),
    .link_oe    (link_oe),
    .link_in    (link_in),
    .link_strobe(link_strobe),
    .link_we    (link_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Link slave and response scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (link_strobe && link_oe) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 32'(link_out), 32'hFFFF_FFFF);
        end else begin
          b = beat_q.pop_front();
          chk("beat_data", 32'(link_out), 32'(b.data));
          chk("beat_we", 32'(link_we), 32'(b.we));
        end
      end else if (link_strobe) begin
        chk("rd_beat_out_zero", 32'(link_out), 32'h0);
        chk("rd_beat_we", 32'(link_we), 32'h0);
        if (rd_q.size() == 0) chk("rd_beat_unexpected", 32'h1, 32'h0);
        else                  link_in = rd_q.pop_front();
      end else begin
        chk("oe_off", 32'(link_oe), 32'h0);
        if (!link_oe) chk("out_zero", 32'(link_out), 32'h0);
      end
      if (rsp_valid) begin
        chk("ready_in_resp", 32'(req_ready), 32'h0);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'h1, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_latency", 32'(cyc), 32'(r.due));
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance with req_valid still high.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [15:0] rlo, input logic [15:0] rhi, input int exp_wait);
    int          waited;
    logic [31:0] la;
    rsp_t        e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk("accept_wait", 32'(waited), 32'(exp_wait));
`ifdef RAM_SERDES_ALIGN_CHK_EN
    if (addr[1:0] != 2'b00) begin
      e.rdata = last_rdata;
      e.err   = 1'b1;
      e.due   = cyc + 1;
      rsp_q.push_back(e);
      @(negedge clk);
      return;
    end
`endif
    la = addr & 32'hFFFF_FFFC;
    beat_q.push_back('{data: la[15:0], we: we});
    beat_q.push_back('{data: la[31:16], we: we});
    if (we) begin
      beat_q.push_back('{data: wdata[15:0], we: 1'b1});
      beat_q.push_back('{data: wdata[31:16], we: 1'b1});
      e.due = cyc + 5;
    end else begin
      rd_q.push_back(rlo);
      rd_q.push_back(rhi);
      last_rdata = {rhi, rlo};
      e.due = cyc + 5 + TC;
    end
    e.rdata = last_rdata;
    e.err   = 1'b0;
    rsp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp", 32'(rsp_q.size()), 32'h0);
    chk("drain_beats", 32'(beat_q.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_oe", 32'(link_oe), 32'h0);
    chk("rst_strobe", 32'(link_strobe), 32'h0);
    chk("rst_we", 32'(link_we), 32'h0);
    chk("rst_out", 32'(link_out), 32'h0);
    rst_n = 1'b1;

    do_req(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 16'h0, 16'h0, 0);
    idle();
    drain();
    do_req(1'b0, 32'h0000_0010, 32'h0, 16'h5678, 16'h1234, 0);
    idle();
    drain();

    // req_valid held high across consecutive requests
    do_req(1'b1, 32'h0000_0100, 32'h1111_2222, 16'h0, 16'h0, 0);
    do_req(1'b1, 32'h0000_0104, 32'h3333_4444, 16'h0, 16'h0, 5);
    do_req(1'b0, 32'h0000_0108, 32'h0, 16'hAAAA, 16'h5555, 5);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 16'h0F0F, 16'hF0F0, 5 + TC);
    do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 16'h0, 16'h0, 5 + TC);
    idle();
    drain();

    // misaligned address
    do_req(1'b0, 32'h0000_0002, 32'h0, 16'h1357, 16'h2468, 0);
    idle();
    drain();
    do_req(1'b1, 32'h0000_0003, 32'h9999_8888, 16'h0, 16'h0, -1);
    idle();
    drain();

    for (int i = 0; i < 6; i++) begin
      do_req(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
             16'($urandom), 16'($urandom), -1);
      idle();
    end
    drain();

    // reset while in ADDR_HI
    do_req(1'b1, 32'h0000_4000, 32'h7777_6666, 16'h0, 16'h0, 0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(link_oe), 32'h0);
    chk("arst_strobe", 32'(link_strobe), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_rdata", rsp_rdata, 32'h0);
    rsp_q.delete();
    beat_q.delete();
    rd_q.delete();
    last_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0020, 32'h0, 16'hBEEF, 16'hFACE, 0);
    idle();
    drain();
    do_req(1'b1, 32'h0000_0024, 32'h0102_0304, 16'h0, 16'h0, 0);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
